// File: rtl/fw_stream_loader_if.sv
// Bus bundle between the firmware loader, the byte-stream source and the
// memory data port it borrows while the core is held in reset.
interface fw_stream_loader_if;
    // Byte stream (ready/valid)
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;

    // Memory data port
    logic        mem_wren;
    logic        mem_rden;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    // Loader side: consumes the stream, initiates memory requests
    modport master (
        input  in_valid, in_data, mem_rdata,
        output in_ready, mem_wren, mem_rden, mem_addr, mem_wdata, mem_wstrb
    );

    // Environment side: stream source plus memory model
    modport slave (
        output in_valid, in_data, mem_rdata,
        input  in_ready, mem_wren, mem_rden, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/fw_stream_loader.sv
// Loads a LEN/payload/SUM byte stream into memory as little-endian words,
// reads it back to verify the checksum, and releases core reset on success.
module fw_stream_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 65536
) (
    input  logic                      clk,
    input  logic                      resetn,
    fw_stream_loader_if.master        bus,
    output logic                      core_resetn,
    output logic                      load_done,
    output logic                      load_err
);

    localparam logic [31:0] MEM_BYTES_W = 32'(MEM_BYTES);

    typedef enum logic [2:0] {
        S_HDR,
        S_DATA,
        S_WR,
        S_TRL,
        S_RD,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t      r_state;
    logic [31:0] r_len;
    logic [31:0] r_sum_exp;
    logic [1:0]  r_fld_cnt;
    logic [31:0] r_pay_cnt;
    logic [31:0] r_word_idx;
    logic [31:0] r_buf;
    logic [3:0]  r_strb;
    logic [31:0] r_acc;

    logic        r_in_ready;
    logic        r_mem_wren;
    logic        r_mem_rden;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wstrb;
    logic        r_core_resetn;
    logic        r_load_done;
    logic        r_load_err;

    logic        w_xfer;
    logic [31:0] w_len_next;
    logic [31:0] w_sum_next;
    logic [1:0]  w_lane;
    logic [31:0] w_buf_next;
    logic [3:0]  w_strb_next;
    logic [31:0] w_pay_cnt_next;
    logic        w_last_byte;
    logic [31:0] w_nwords;
    logic        w_last_word;
    logic [31:0] w_word_idx_inc;
    logic [31:0] w_addr_cur;
    logic [31:0] w_addr_inc;
    logic [3:0]  w_rd_strb;
    logic [31:0] w_rd_mask;

    assign w_xfer         = bus.in_valid & r_in_ready;

    // Header and trailer fields arrive LSB first, so new bytes enter at the top.
    assign w_len_next     = {bus.in_data, r_len[31:8]};
    assign w_sum_next     = {bus.in_data, r_sum_exp[31:8]};

    assign w_lane         = r_pay_cnt[1:0];
    assign w_buf_next     = r_buf | (32'(bus.in_data) << {w_lane, 3'b000});
    assign w_strb_next    = r_strb | (4'b0001 << w_lane);
    assign w_pay_cnt_next = r_pay_cnt + 32'd1;
    assign w_last_byte    = (w_pay_cnt_next == r_len);

    assign w_nwords       = {2'b00, r_len[31:2]} + {31'b0, |r_len[1:0]};
    assign w_last_word    = (r_word_idx == (w_nwords - 32'd1));
    assign w_word_idx_inc = r_word_idx + 32'd1;
    assign w_addr_cur     = BASE_ADDR + {r_word_idx[29:0], 2'b00};
    assign w_addr_inc     = BASE_ADDR + {w_word_idx_inc[29:0], 2'b00};

    // Readback only trusts the lanes that were actually written.
    always_comb begin
        w_rd_strb = 4'hF;
        w_rd_mask = '0;
        if (w_last_word && (r_len[1:0] != 2'b00)) begin
            w_rd_strb = (4'b0001 << r_len[1:0]) - 4'b0001;
        end
        for (int b = 0; b < 4; b++) begin
            w_rd_mask[8*b +: 8] = {8{w_rd_strb[b]}};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_HDR;
            r_len         <= '0;
            r_sum_exp     <= '0;
            r_fld_cnt     <= '0;
            r_pay_cnt     <= '0;
            r_word_idx    <= '0;
            r_buf         <= '0;
            r_strb        <= '0;
            r_acc         <= '0;
            r_in_ready    <= 1'b0;
            r_mem_wren    <= 1'b0;
            r_mem_rden    <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_wstrb   <= '0;
            r_core_resetn <= 1'b0;
            r_load_done   <= 1'b0;
            r_load_err    <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults here are overridden by later assignments
            // in the same cycle, so the bus idles at zero outside WR/RD.
            r_mem_wren  <= 1'b0;
            r_mem_rden  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;

            case (r_state)
                S_HDR: begin
                    r_in_ready <= 1'b1;
                    if (w_xfer) begin
                        r_len     <= w_len_next;
                        r_fld_cnt <= r_fld_cnt + 2'd1;
                        if (r_fld_cnt == 2'd3) begin
                            if (w_len_next > MEM_BYTES_W) begin
                                r_state     <= S_ERR;
                                r_in_ready  <= 1'b0;
                                r_load_done <= 1'b1;
                                r_load_err  <= 1'b1;
                            end else if (w_len_next == 32'd0) begin
                                r_state <= S_TRL;
                            end else begin
                                r_state <= S_DATA;
                            end
                        end
                    end
                end

                S_DATA: begin
                    if (w_xfer) begin
                        r_buf     <= w_buf_next;
                        r_strb    <= w_strb_next;
                        r_pay_cnt <= w_pay_cnt_next;
                        if ((w_lane == 2'd3) || w_last_byte) begin
                            r_state     <= S_WR;
                            r_in_ready  <= 1'b0;
                            r_mem_wren  <= 1'b1;
                            r_mem_addr  <= w_addr_cur;
                            r_mem_wdata <= w_buf_next;
                            r_mem_wstrb <= w_strb_next;
                        end
                    end
                end

                S_WR: begin
                    r_buf      <= '0;
                    r_strb     <= '0;
                    r_word_idx <= w_word_idx_inc;
                    r_in_ready <= 1'b1;
                    r_state    <= (r_pay_cnt == r_len) ? S_TRL : S_DATA;
                end

                S_TRL: begin
                    if (w_xfer) begin
                        r_sum_exp <= w_sum_next;
                        r_fld_cnt <= r_fld_cnt + 2'd1;
                        if (r_fld_cnt == 2'd3) begin
                            r_in_ready <= 1'b0;
                            r_word_idx <= '0;
                            r_acc      <= '0;
                            if (r_len == 32'd0) begin
                                r_state <= S_CHK;
                            end else begin
                                r_state    <= S_RD;
                                r_mem_rden <= 1'b1;
                                r_mem_addr <= BASE_ADDR;
                            end
                        end
                    end
                end

                // mem_rdata for the current request is valid at this edge.
                S_RD: begin
                    r_acc <= r_acc + (bus.mem_rdata & w_rd_mask);
                    if (w_last_word) begin
                        r_state <= S_CHK;
                    end else begin
                        r_word_idx <= w_word_idx_inc;
                        r_mem_rden <= 1'b1;
                        r_mem_addr <= w_addr_inc;
                    end
                end

                S_CHK: begin
                    r_load_done <= 1'b1;
                    if (r_acc == r_sum_exp) begin
                        r_state       <= S_DONE;
                        r_core_resetn <= 1'b1;
                    end else begin
                        r_state    <= S_ERR;
                        r_load_err <= 1'b1;
                    end
                end

                S_DONE: begin
                    r_in_ready <= 1'b0;
                end

                S_ERR: begin
                    r_in_ready <= 1'b0;
                end

                default: begin
                    r_state <= S_ERR;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.mem_wren  = r_mem_wren;
    assign bus.mem_rden  = r_mem_rden;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_wstrb = r_mem_wstrb;
    assign core_resetn   = r_core_resetn;
    assign load_done     = r_load_done;
    assign load_err      = r_load_err;

endmodule

// File: tb/tb_fw_stream_loader.sv
// Directed and randomized loads against a byte-level image model, with a
// negedge memory model and a bus-rule monitor beside the loader.
module tb_fw_stream_loader;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          MEMB  = 64;

    typedef logic [7:0] bytes_t [$];
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    logic core_resetn;
    logic load_done;
    logic load_err;

    fw_stream_loader_if bus_if ();

    fw_stream_loader #(
        .BASE_ADDR (BASE),
        .MEM_BYTES (MEMB)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus_if),
        .core_resetn (core_resetn),
        .load_done   (load_done),
        .load_err    (load_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory model: samples requests on negedge, optional bulk fill.
    logic [31:0] mem [0:255];
    logic        fill_en  = 1'b0;
    logic [31:0] fill_val = '0;

    always @(negedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= fill_val;
        end else begin
            if (bus_if.mem_wren) begin
                for (int b = 0; b < 4; b++)
                    if (bus_if.mem_wstrb[b])
                        mem[bus_if.mem_addr[9:2]][8*b +: 8] <= bus_if.mem_wdata[8*b +: 8];
            end
            if (bus_if.mem_rden) bus_if.mem_rdata <= mem[bus_if.mem_addr[9:2]];
        end
    end

    // Bus monitor: logs requests and counts rule violations.
    wr_t         wr_log [$];
    logic [31:0] rd_log [$];
    int          viol = 0;

    always @(negedge clk) begin
        if (resetn) begin
            if (bus_if.mem_wren) wr_log.push_back('{bus_if.mem_addr, bus_if.mem_wdata, bus_if.mem_wstrb});
            if (bus_if.mem_rden) rd_log.push_back(bus_if.mem_addr);
            if (bus_if.mem_wren && bus_if.mem_rden) viol++;
            if (!bus_if.mem_wren && !bus_if.mem_rden &&
                ((bus_if.mem_addr != 0) || (bus_if.mem_wdata != 0) || (bus_if.mem_wstrb != 0))) viol++;
            if (bus_if.in_ready && (bus_if.mem_wren || bus_if.mem_rden)) viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " in_ready"},    32'(bus_if.in_ready),  0);
        check({tag, " mem_wren"},    32'(bus_if.mem_wren),  0);
        check({tag, " mem_rden"},    32'(bus_if.mem_rden),  0);
        check({tag, " mem_addr"},    bus_if.mem_addr,       0);
        check({tag, " mem_wdata"},   bus_if.mem_wdata,      0);
        check({tag, " mem_wstrb"},   32'(bus_if.mem_wstrb), 0);
        check({tag, " core_resetn"}, 32'(core_resetn),      0);
        check({tag, " load_done"},   32'(load_done),        0);
        check({tag, " load_err"},    32'(load_err),         0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input string tag);
        int t = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = b;
        while (!bus_if.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check({tag, " in_ready timeout"}, 32'(bus_if.in_ready), 1);
        @(posedge clk);
        #1 bus_if.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap, input string tag);
        for (int k = 0; k < 4; k++) send_byte(8'(w >> (8 * k)), gap, tag);
    endtask

    task automatic apply_reset(input logic [31:0] fill);
        @(negedge clk);
        resetn   = 1'b0;
        fill_val = fill;
        fill_en  = 1'b1;
        @(negedge clk);
        fill_en  = 1'b0;
        @(negedge clk);
        resetn   = 1'b1;
    endtask

    // Image model: little-endian packing of payload bytes, zero-padded tail.
    function automatic logic [31:0] image_sum(input logic [31:0] len, input bytes_t pay);
        logic [31:0] s = 0;
        for (int i = 0; i < int'(len); i++) s += 32'(pay[i]) << (8 * (i % 4));
        return s;
    endfunction

    task automatic run_load(input string tag, input logic [31:0] len, input bytes_t pay,
                            input logic [31:0] sum, input int gap, input logic [31:0] fill);
        logic [31:0] ew [$];
        logic [3:0]  es [$];
        int          wr0, rd0, v0, t, nw;
        logic        reject, exp_err;

        apply_reset(fill);
        wr0 = wr_log.size();
        rd0 = rd_log.size();
        v0  = viol;

        reject = (len > 32'(MEMB));
        nw     = reject ? 0 : (int'(len) + 3) / 4;
        for (int i = 0; i < nw * 4 && i < int'(len); i++) begin
            logic [31:0] w;
            logic [3:0]  s;
            if (i % 4 == 0) begin
                ew.push_back(0);
                es.push_back(0);
            end
            w = ew[i / 4];
            s = es[i / 4];
            w[8 * (i % 4) +: 8] = pay[i];
            s[i % 4] = 1'b1;
            ew[i / 4] = w;
            es[i / 4] = s;
        end
        exp_err = reject || (image_sum(len, pay) != sum);

        send_word(len, gap, tag);
        if (!reject) begin
            for (int i = 0; i < int'(len); i++) send_byte(pay[i], gap, tag);
            send_word(sum, gap, tag);
        end

        t = 0;
        while (!load_done && t < 2000) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);

        check({tag, " load_done"},   32'(load_done),   1);
        check({tag, " load_err"},    32'(load_err),    32'(exp_err));
        check({tag, " core_resetn"}, 32'(core_resetn), 32'(!exp_err));
        check({tag, " in_ready"},    32'(bus_if.in_ready), 0);
        check({tag, " writes"},      32'(wr_log.size() - wr0), 32'(nw));
        for (int i = 0; i < nw && (wr0 + i) < wr_log.size(); i++) begin
            check($sformatf("%s wr%0d addr", tag, i), wr_log[wr0 + i].addr, BASE + 32'(4 * i));
            check($sformatf("%s wr%0d data", tag, i), wr_log[wr0 + i].data, ew[i]);
            check($sformatf("%s wr%0d strb", tag, i), 32'(wr_log[wr0 + i].strb), 32'(es[i]));
        end
        check({tag, " reads"}, 32'(rd_log.size() - rd0), 32'(nw));
        for (int i = 0; i < nw && (rd0 + i) < rd_log.size(); i++)
            check($sformatf("%s rd%0d addr", tag, i), rd_log[rd0 + i], BASE + 32'(4 * i));
        check({tag, " bus rules"}, 32'(viol - v0), 0);
    endtask

    initial begin
        bytes_t p;
        bytes_t empty;
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = '0;

        #1 resetn = 1'b0;
        #2 check_outputs_zero("reset");
        @(negedge clk);
        resetn = 1'b1;

        // Eight full-word bytes, correct checksum.
        p = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_load("len8", 32'd8, p, 32'h0C0A_0806, 0, 32'h0);

        // Partial last word over pre-filled 0xFFFFFFFF memory.
        p = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run_load("len5", 32'd5, p, 32'h4433_2266, 0, 32'hFFFF_FFFF);

        // Bad checksum.
        p = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_load("badsum", 32'd8, p, 32'h0C0A_0807, 0, 32'h0);

        // Oversized LEN values and the largest legal image.
        run_load("len_huge", 32'h0001_0004, empty, 32'h0, 0, 32'h0);
        run_load("len_max+1", 32'(MEMB + 1), empty, 32'h0, 0, 32'h0);
        p = {};
        for (int i = 0; i < MEMB; i++) p.push_back(8'($urandom));
        run_load("len_max", 32'(MEMB), p, image_sum(32'(MEMB), p), 0, $urandom);

        // Empty image.
        run_load("len0", 32'd0, empty, 32'h0, 0, 32'h0);

        // Abort mid-payload with toggling in_valid, then a fresh load.
        apply_reset(32'h0);
        send_word(32'd8, 1, "abort");
        for (int i = 0; i < 3; i++) send_byte(8'(i + 1), 1, "abort");
        check("abort in_ready before reset", 32'(bus_if.in_ready), 1);
        #3 resetn = 1'b0;
        #1 check_outputs_zero("abort");
        @(negedge clk);
        resetn = 1'b1;
        p = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_load("after_abort", 32'd8, p, 32'h0C0A_0806, 1, 32'h0);

        // Randomized images, some with corrupted checksums.
        for (int n = 0; n < 8; n++) begin
            int          len;
            logic [31:0] s;
            len = $urandom_range(1, MEMB);
            p = {};
            for (int i = 0; i < len; i++) p.push_back(8'($urandom));
            s = image_sum(32'(len), p);
            if ($urandom_range(0, 3) == 0) s = s ^ (32'd1 << $urandom_range(0, 31));
            run_load($sformatf("rand%0d", n), 32'(len), p, s, $urandom_range(0, 1), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
